tag_alloc_buffer: RTL and testbench

//  Read-side client of the physical-register free list. Issues free-list reads, captures the

---
 rtl/tag_alloc_buffer.sv | 103 ++++++++++
 tb/tb_tag_alloc_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tag_alloc_buffer.sv
// Tag allocation buffer: prefetches physical register tags from the free list into a small FIFO.
// Optional TAG_CHECK_EN drops captured tag 0 and raises a sticky tag_err.
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

module tag_alloc_buffer #(
   parameter int TAG_W = `CDB_BITS,
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             fl_empty,
   output logic             fl_rd,
   input  logic [TAG_W-1:0] fl_data,
   input  logic             alloc_ready,
   output logic             alloc_valid,
   output logic [TAG_W-1:0] alloc_tag,
   output logic             tag_err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

   logic [TAG_W-1:0] tagBuf_q [DEPTH];
   logic [PW-1:0]    rdPtr_q, rdPtr_d;
   logic [PW-1:0]    wrPtr_q, wrPtr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             inflight_q;
   logic             pop;
   logic             push;
   logic             tagOk;
   logic [CW:0]      occupancy;

   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   // The read request counts the pop happening this cycle so the buffer streams at full occupancy.
   always_comb begin
      alloc_valid = reset && (count_q != '0);
      alloc_tag   = alloc_valid ? tagBuf_q[rdPtr_q] : '0;
      pop         = alloc_valid && alloc_ready;
`ifdef TAG_CHECK_EN
      tagOk       = (fl_data != '0);
`else
      tagOk       = 1'b1;
`endif
      push        = inflight_q && tagOk;
      occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
      fl_rd       = reset && !fl_empty && (occupancy < DEPTH_C);
      rdPtr_d     = pop  ? nextPtr(rdPtr_q) : rdPtr_q;
      wrPtr_d     = push ? nextPtr(wrPtr_q) : wrPtr_q;
      count_d     = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q    <= '0;
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         inflight_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) tagBuf_q[i] <= '0;
      end else begin
         count_q    <= count_d;
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         inflight_q <= fl_rd;
         if (push) tagBuf_q[wrPtr_q] <= fl_data;
      end
   end

`ifdef TAG_CHECK_EN
   logic tagErr_q;

   // A rejected capture still consumes its free-list slot; only the error flag records it.
   always_ff @(posedge clock) begin
      if (!reset) tagErr_q <= 1'b0;
      else if (inflight_q && !tagOk) tagErr_q <= 1'b1;
   end

   assign tag_err = tagErr_q;
`else
   assign tag_err = 1'b0;
`endif

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (reset) begin
         assert ({1'b0, count_q} <= DEPTH_C);
         assert (!(push && !pop && ({1'b0, count_q} == DEPTH_C)));
      end
   end
`endif

endmodule

// File: tb/tb_tag_alloc_buffer.sv
// Testbench for tag_alloc_buffer: behavioural free list plus a scoreboard of expected tags.
// Builds with or without TAG_CHECK_EN; expectations follow the same macro.
module tb_tag_alloc_buffer;

   localparam int TAG_W = 8;
   localparam int DEPTH = 2;

`ifdef TAG_CHECK_EN
   localparam int ERR_EXP    = 1;
   localparam int VALID2_EXP = 0;
`else
   localparam int ERR_EXP    = 0;
   localparam int VALID2_EXP = 1;
`endif

   logic             clock = 1'b0;
   logic             reset;
   logic             flEmpty;
   logic             flRd;
   logic [TAG_W-1:0] flData;
   logic             allocReady;
   logic             allocValid;
   logic [TAG_W-1:0] allocTag;
   logic             tagErr;

   int checks = 0;
   int errors = 0;

   int expQ[$];
   int nextTag = 33;
   int readsSinceReset = 0;
   int zeroAt = -1;
   int delivered = 0;
   int issueTag = 0;
   logic rdPending = 1'b0;

   tag_alloc_buffer #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clock       (clock),
      .reset       (reset),
      .fl_empty    (flEmpty),
      .fl_rd       (flRd),
      .fl_data     (flData),
      .alloc_ready (allocReady),
      .alloc_valid (allocValid),
      .alloc_tag   (allocTag),
      .tag_err     (tagErr)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic rdy, input logic empty);
      @(posedge clock);
      #1;
      reset      = rst;
      allocReady = rdy;
      flEmpty    = empty;
   endtask

   // Free-list model and scoreboard: reads are decided mid-cycle, data appears after the next edge.
   always @(negedge clock) begin
      if (!reset) begin
         expQ.delete();
         nextTag         = 33;
         readsSinceReset = 0;
         delivered       = 0;
         rdPending       = 1'b0;
      end else begin
         if (allocValid && allocReady) begin
            checkOutput("sbHasEntry", int'(expQ.size() != 0), 1);
            if (expQ.size() != 0) begin
               checkOutput("sbTag", int'(allocTag), expQ.pop_front());
               delivered++;
            end
         end
         rdPending = flRd;
         if (flRd) begin
            issueTag = (readsSinceReset == zeroAt) ? 0 : nextTag;
            if (issueTag != 0) nextTag++;
`ifdef TAG_CHECK_EN
            if (issueTag != 0) expQ.push_back(issueTag);
`else
            expQ.push_back(issueTag);
`endif
            readsSinceReset++;
         end
      end
   end

   always @(posedge clock) begin
      if (!reset) flData <= '0;
      else if (rdPending) flData <= issueTag[TAG_W-1:0];
   end

   initial begin
      int cycles;
      reset      = 1'b0;
      allocReady = 1'b0;
      flEmpty    = 1'b0;

      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      @(negedge clock);
      checkOutput("rstFlRd", int'(flRd), 0);
      checkOutput("rstValid", int'(allocValid), 0);
      checkOutput("rstTag", int'(allocTag), 0);
      checkOutput("rstErr", int'(tagErr), 0);

      // Fill with no consumer: two reads, then the buffer holds 33 and 34.
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1, 0, 0);
         @(negedge clock);
         checkOutput("s1FlRd", int'(flRd), (c < 2) ? 1 : 0);
         checkOutput("s1Valid", int'(allocValid), (c >= 2) ? 1 : 0);
         checkOutput("s1Tag", int'(allocTag), (c >= 2) ? 33 : 0);
      end

      // Drain with the free list empty.
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1, 1, 1);
         @(negedge clock);
         checkOutput("s3FlRd", int'(flRd), 0);
         checkOutput("s3Valid", int'(allocValid), (c < 2) ? 1 : 0);
         checkOutput("s3Tag", int'(allocTag), (c == 0) ? 33 : (c == 1) ? 34 : 0);
      end

      // Streaming from reset with a consumer that is always ready.
      applyStimulus(0, 0, 0);
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1, 1, 0);
         @(negedge clock);
         checkOutput("s2FlRd", int'(flRd), 1);
         checkOutput("s2Valid", int'(allocValid), (c >= 2) ? 1 : 0);
         checkOutput("s2Tag", int'(allocTag), (c >= 2) ? 33 + c - 2 : 0);
      end

      // Reset while a tag is buffered and another is in flight.
      applyStimulus(0, 1, 0);
      @(negedge clock);
      checkOutput("s4RstFlRd", int'(flRd), 0);
      checkOutput("s4RstValid", int'(allocValid), 0);
      checkOutput("s4RstTag", int'(allocTag), 0);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1, 0, 0);
         @(negedge clock);
         checkOutput("s4FlRd", int'(flRd), (c < 2) ? 1 : 0);
         checkOutput("s4Valid", int'(allocValid), (c == 2) ? 1 : 0);
         checkOutput("s4Tag", int'(allocTag), (c == 2) ? 33 : 0);
      end

      // Random backpressure until twenty tags have come out in order.
      applyStimulus(0, 0, 0);
      cycles = 0;
      while (delivered < 20 && cycles < 300) begin
         applyStimulus(1, 1'($urandom_range(0, 1)), 0);
         @(negedge clock);
         cycles++;
      end
      checkOutput("s5Delivered", int'(delivered >= 20), 1);

      // First free-list read returns tag 0.
      applyStimulus(0, 0, 0);
      zeroAt = 0;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1, 1, 0);
         @(negedge clock);
         checkOutput("s6Err", int'(tagErr), (c >= 2) ? ERR_EXP : 0);
         if (c == 2) begin
            checkOutput("s6Valid", int'(allocValid), VALID2_EXP);
            checkOutput("s6Tag", int'(allocTag), 0);
         end
      end
      zeroAt = -1;
      applyStimulus(0, 0, 0);
      @(negedge clock);
      checkOutput("s6ErrInRst", int'(tagErr), ERR_EXP);
      applyStimulus(1, 0, 0);
      @(negedge clock);
      checkOutput("s6ErrCleared", int'(tagErr), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
